bram_stream_loader: RTL and testbench
=====================================

Name: bram_stream_loader

Overview:
- Upstream feeder for data_mover_bram.
- Accepts a valid/ready stream of packed 32-bit words. Each word holds four 8-bit lanes, MSB lane first.
- Writes the first i_num_cnt words into the node BRAM (bank 0) and the next i_num_cnt words into the weight BRAM (bank 1), through port B of each true_dpbram.
- Signals o_done once both banks are fully written, so the controller can then pulse i_run of the data mover.

Parameters:
- CNT_BIT, 31, width of the word-count input.
- DWIDTH, 32, BRAM and stream data width.
- AWIDTH, 12, BRAM address width.
- MEM_SIZE, 4096, BRAM depth in words; the count saturates at this value.

Ports:
- clk  in  1  system clock, all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- i_run  in  1  start pulse, sampled only in IDLE
- i_num_cnt  in  CNT_BIT  words per bank, latched on accepted i_run
- o_idle  out  1  high in IDLE
- o_load  out  1  high in LOAD_B0, LOAD_B1 and FLUSH
- o_done  out  1  one-cycle pulse in DONE
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  DWIDTH  stream word
- addr_b0  out  AWIDTH  bank 0 write address
- ce_b0  out  1  bank 0 chip enable
- we_b0  out  1  bank 0 write enable
- d_b0  out  DWIDTH  bank 0 write data
- addr_b1  out  AWIDTH  bank 1 write address
- ce_b1  out  1  bank 1 chip enable
- we_b1  out  1  bank 1 write enable
- d_b1  out  DWIDTH  bank 1 write data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - State = IDLE, so o_idle=1.
  - o_load=0, o_done=0, s_ready=0.
  - All addr/ce/we/d outputs = 0.
  - Word counter = 0, latched count = 0.
- FSM states: IDLE, LOAD_B0, LOAD_B1, FLUSH, DONE.
- IDLE:
  - On i_run=1, latch min(i_num_cnt, MEM_SIZE) as N and clear the counter.
  - If N=0, go to DONE; otherwise go to LOAD_B0.
  - i_run is ignored in every state other than IDLE.
- LOAD_B0 and LOAD_B1:
  - s_ready=1, driven combinationally from state only; it never depends on s_valid.
  - A handshake occurs when s_valid && s_ready.
  - Each handshake registers one write on the current bank, visible the next cycle: ce=1, we=1, addr=counter[AWIDTH-1:0], d=s_data.
  - In a cycle with no handshake, the bank's ce/we = 0. addr/d hold their last value.
  - After a handshake, counter increments. On the handshake with counter=N-1, counter clears to 0 and the state advances: LOAD_B0→LOAD_B1, LOAD_B1→FLUSH.
  - The bank switch costs no bubble: word N goes to bank 1 address 0 in the very next accepted cycle.
- FLUSH: one cycle, s_ready=0. The final bank 1 write strobe is visible during this cycle. Next state is DONE.
- DONE: one cycle, o_done=1, s_ready=0. Next state is IDLE.
- Latency and throughput:
  - Handshake at cycle T gives the BRAM write strobe at T+1.
  - The last bank 1 handshake at T gives o_done at T+2.
  - Sustained rate is 1 word/cycle.
- Port B ce/we are never asserted for reads. Both bank strobes are never high in the same cycle, including at the bank switch.
- Counter width is AWIDTH+1 so that a value of MEM_SIZE is representable. Address wraps are impossible because N ≤ MEM_SIZE.
- Reset mid-load: returns to IDLE at once and all strobes drop asynchronously. BRAM contents already written are left as is. No o_done is emitted.
- Back-pressure: s_valid may drop at any cycle. The loader holds state and counter until the next handshake. There is no timeout.

Optional Feature:
- Macro: BRAM_LOADER_CHECKSUM_EN.
- When defined:
  - Add output o_checksum [DWIDTH-1:0].
  - o_checksum is a running modulo-2^32 sum of the four 8-bit lanes (zero-extended) of every accepted word, covering both banks.
  - It is cleared on accepted i_run and on reset.
  - It is stable from DONE until the next accepted i_run.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then i_run with i_num_cnt=4 and s_valid held high. Stream words 0x01020304+k for k=0..7:
  - bank 0 addr 0..3 holds k=0..3 and bank 1 addr 0..3 holds k=4..7;
  - o_done pulses exactly 1 cycle, 2 cycles after the 8th handshake;
  - o_idle=1 on the next cycle.
- Same run with s_valid toggling 1,0,0,1,…:
  - BRAM contents identical to the previous test;
  - we_b0/we_b1 asserted exactly 4 times each;
  - no strobe in any cycle without a handshake.
- i_num_cnt=0:
  - o_done pulses 1 cycle after i_run;
  - s_ready stays 0;
  - no BRAM strobes.
- i_num_cnt=5000 with MEM_SIZE=4096: exactly 4096 writes per bank, bank 0 last address 4095, then o_done.
- Reset asserted after 3 of 8 words:
  - all outputs return to reset values without waiting for a clock edge;
  - a new i_run with i_num_cnt=2 completes normally;
  - i_run pulses during LOAD_B0 have no effect.
- With BRAM_LOADER_CHECKSUM_EN, stream 8 words of 0xFFFFFFFF with i_num_cnt=4: o_checksum=0x00001FE0 at o_done.

Source files
------------

// File: rtl/bram_stream_loader.sv
// Stream-to-BRAM loader: first N words to bank 0, next N words to bank 1, then o_done.
// Optional running lane checksum on o_checksum when BRAM_LOADER_CHECKSUM_EN is defined.
module bram_stream_loader #(
    parameter int CNT_BIT  = 31,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_load,
    output logic              o_done,
`ifdef BRAM_LOADER_CHECKSUM_EN
    output logic [DWIDTH-1:0] o_checksum,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic [AWIDTH-1:0] addr_b0,
    output logic              ce_b0,
    output logic              we_b0,
    output logic [DWIDTH-1:0] d_b0,
    output logic [AWIDTH-1:0] addr_b1,
    output logic              ce_b1,
    output logic              we_b1,
    output logic [DWIDTH-1:0] d_b1
);
    localparam int CW = AWIDTH + 1;
    localparam logic [CNT_BIT-1:0] MEM_SIZE_C = CNT_BIT'(MEM_SIZE);

    typedef enum logic [2:0] {IDLE, LOAD_B0, LOAD_B1, FLUSH, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, r_num, w_num_sat;
    logic              w_hs, w_last;
    logic              r_wr_b0, r_wr_b1;
    logic [AWIDTH-1:0] r_addr_b0, r_addr_b1;
    logic [DWIDTH-1:0] r_d_b0, r_d_b1;

    assign w_num_sat = (i_num_cnt > MEM_SIZE_C) ? CW'(MEM_SIZE) : i_num_cnt[CW-1:0];
    assign w_hs      = s_valid && s_ready;
    assign w_last    = (r_cnt + CW'(1)) == r_num;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_idle      = 1'b0;
        o_load      = 1'b0;
        o_done      = 1'b0;
        s_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                o_idle = 1'b1;
                if (i_run) w_state_nxt = (w_num_sat == '0) ? DONE : LOAD_B0;
            end
            LOAD_B0: begin
                o_load  = 1'b1;
                s_ready = 1'b1;
                if (s_valid && w_last) w_state_nxt = LOAD_B1;
            end
            LOAD_B1: begin
                o_load  = 1'b1;
                s_ready = 1'b1;
                if (s_valid && w_last) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                o_load      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write strobes last exactly one cycle per handshake; addr/data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_num     <= '0;
            r_wr_b0   <= 1'b0;
            r_wr_b1   <= 1'b0;
            r_addr_b0 <= '0;
            r_addr_b1 <= '0;
            r_d_b0    <= '0;
            r_d_b1    <= '0;
        end else begin
            r_wr_b0 <= 1'b0;
            r_wr_b1 <= 1'b0;
            if (r_state == IDLE && i_run) begin
                r_num <= w_num_sat;
                r_cnt <= '0;
            end
            if (w_hs) begin
                if (r_state == LOAD_B0) begin
                    r_wr_b0   <= 1'b1;
                    r_addr_b0 <= r_cnt[AWIDTH-1:0];
                    r_d_b0    <= s_data;
                end else begin
                    r_wr_b1   <= 1'b1;
                    r_addr_b1 <= r_cnt[AWIDTH-1:0];
                    r_d_b1    <= s_data;
                end
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    assign addr_b0 = r_addr_b0;
    assign ce_b0   = r_wr_b0;
    assign we_b0   = r_wr_b0;
    assign d_b0    = r_d_b0;
    assign addr_b1 = r_addr_b1;
    assign ce_b1   = r_wr_b1;
    assign we_b1   = r_wr_b1;
    assign d_b1    = r_d_b1;

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [DWIDTH-1:0] r_sum, w_lane_sum;

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < DWIDTH / 8; i++)
            w_lane_sum = w_lane_sum + DWIDTH'(s_data[8*i +: 8]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_sum <= '0;
        else if (r_state == IDLE && i_run)  r_sum <= '0;
        else if (w_hs)                      r_sum <= r_sum + w_lane_sum;
    end

    assign o_checksum = r_sum;
`endif
endmodule

// File: tb/tb_bram_stream_loader.sv
// Scoreboard bench for bram_stream_loader: stimulus queues expected writes/done, monitor checks.
module tb_bram_stream_loader;
    logic        clk, reset, i_run, s_valid;
    logic [30:0] i_num_cnt;
    logic [31:0] s_data;
    logic        o_idle, o_load, o_done, s_ready;
    logic [11:0] addr_b0, addr_b1;
    logic        ce_b0, we_b0, ce_b1, we_b1;
    logic [31:0] d_b0, d_b1;
`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [31:0] o_checksum;
`endif

    bram_stream_loader dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_load(o_load), .o_done(o_done),
`ifdef BRAM_LOADER_CHECKSUM_EN
        .o_checksum(o_checksum),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d_b0(d_b0),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d_b1(d_b1)
    );

    typedef struct {
        int          cyc;
        int          bank;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  nchecks = 0;
    int  nerr = 0;
    int  wcnt0 = 0;
    int  wcnt1 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor samples 3 time units after each rising edge.
    always @(posedge clk) begin
        wr_t e;
        #3;
        if (ce_b0 || ce_b1 || we_b0 || we_b1) begin
            if (we_b0) wcnt0++;
            if (we_b1) wcnt1++;
            chk("ce_eq_we", {ce_b0, ce_b1}, {we_b0, we_b1});
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {ce_b0, ce_b1}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_bank", {ce_b0, ce_b1}, (e.bank == 0) ? 2'b10 : 2'b01);
                chk("strobe_cycle", cyc, e.cyc);
                chk("wr_addr", (e.bank == 0) ? addr_b0 : addr_b1, e.addr);
                chk("wr_data", (e.bank == 0) ? d_b0 : d_b1, e.data);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) chk("unexpected_done", o_done, 1'b0);
            else                    chk("done_cycle", cyc, done_q.pop_front());
        end
    end

    task automatic start(input int n, input int nsat);
        @(negedge clk);
        i_run     = 1'b1;
        i_num_cnt = 31'(n);
        if (nsat == 0) done_q.push_back(cyc + 1);
        @(negedge clk);
        i_run = 1'b0;
    endtask

    // mode 0: valid always; 1: valid every third cycle; 2: valid always plus i_run pulses
    task automatic stream(input int nsat, input int nwords, input int mode, input bit ff);
        int  k = 0;
        int  i = 0;
        wr_t e;
        if (mode == 2) i_num_cnt = 31'd1;
        while (k < nwords && i < 20000) begin
            s_valid = (mode == 1) ? (i % 3 == 0) : 1'b1;
            s_data  = ff ? 32'hFFFF_FFFF : 32'h0102_0304 + 32'(k);
            i_run   = (mode == 2) ? 1'(i % 2) : 1'b0;
            chk("ready_load", {s_ready, o_load}, 2'b11);
            if (s_valid) begin
                e.cyc  = cyc + 1;
                e.bank = (k < nsat) ? 0 : 1;
                e.addr = 12'((k < nsat) ? k : k - nsat);
                e.data = s_data;
                exp_q.push_back(e);
                k++;
                if (k == 2 * nsat) done_q.push_back(cyc + 2);
            end
            i++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        i_run   = 1'b0;
        if (k < nwords) chk("stream_timeout", 32'(k), 32'(nwords));
        if (k == 2 * nsat) chk("flush_ready", {s_ready, o_load}, 2'b01);
    endtask

    task automatic wait_done();
        int b = 0;
        while ((done_q.size() != 0 || exp_q.size() != 0) && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) chk("done_timeout", 32'(done_q.size() + exp_q.size()), 32'd0);
        @(negedge clk);
        chk("idle_after_done", {o_idle, o_done, s_ready}, 3'b100);
    endtask

    initial begin
        reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; s_valid = 1'b0; s_data = '0;
        #2;
        chk("reset_ctrl", {o_idle, o_load, o_done, s_ready}, 4'b1000);
        chk("reset_b0", {addr_b0, ce_b0, we_b0, d_b0}, 64'd0);
        chk("reset_b1", {addr_b1, ce_b1, we_b1, d_b1}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: N=4, continuous stream
        wcnt0 = 0; wcnt1 = 0;
        start(4, 4);
        stream(4, 8, 0, 0);
        wait_done();
        chk("t1_counts", {wcnt0, wcnt1}, {32'd4, 32'd4});
`ifdef BRAM_LOADER_CHECKSUM_EN
        chk("t1_checksum", o_checksum, 32'h0000_006C);
`endif

        // 2: N=4, valid toggling
        wcnt0 = 0; wcnt1 = 0;
        start(4, 4);
        stream(4, 8, 1, 0);
        wait_done();
        chk("t2_counts", {wcnt0, wcnt1}, {32'd4, 32'd4});

        // 3: N=0
        wcnt0 = 0; wcnt1 = 0;
        start(0, 0);
        s_valid = 1'b1;
        chk("n0_ready", s_ready, 1'b0);
        wait_done();
        s_valid = 1'b0;
        chk("n0_counts", {wcnt0, wcnt1}, 64'd0);

        // 4: saturation to MEM_SIZE
        wcnt0 = 0; wcnt1 = 0;
        start(5000, 4096);
        stream(4096, 8192, 0, 0);
        wait_done();
        chk("sat_counts", {wcnt0, wcnt1}, {32'd4096, 32'd4096});
        chk("sat_last_b0", addr_b0, 12'd4095);

        // 5: reset mid-load after 3 words, i_run pulses ignored
        wcnt0 = 0; wcnt1 = 0;
        start(8, 8);
        stream(8, 3, 2, 0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ctrl", {o_idle, o_load, o_done, s_ready}, 4'b1000);
        chk("midrst_b0", {addr_b0, ce_b0, we_b0, d_b0}, 64'd0);
        chk("midrst_b1", {addr_b1, ce_b1, we_b1, d_b1}, 64'd0);
        chk("midrst_writes", {wcnt0, wcnt1, 32'(exp_q.size())}, {32'd3, 32'd0, 32'd0});
        @(negedge clk);
        reset = 1'b0;
        start(2, 2);
        stream(2, 4, 0, 0);
        wait_done();

`ifdef BRAM_LOADER_CHECKSUM_EN
        // 6: checksum over all-ones words
        start(4, 4);
        stream(4, 8, 0, 1);
        wait_done();
        chk("checksum_ff", o_checksum, 32'h0000_1FE0);
`endif

        repeat (3) @(negedge clk);
        chk("no_leftover", 32'(exp_q.size() + done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end
endmodule
